// File: rtl/data_mem_seq.sv
// Load/store sequencer for a single-ported synchronous data memory with one-cycle read latency.
// Loads read then extend, sub-word stores read-modify-write, word stores write directly.
module data_mem_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_ctrl,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, RESP} state_t;

  state_t                  state_q;
  logic [2:0]              ctrl_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             wdata_q;
  logic [DATA_WIDTH-1:0]   merge_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic                    mem_en_q;
  logic                    mem_we_q;

  logic                    req_err_d;
  logic                    req_word_d;
  logic [DATA_WIDTH-1:0]   load_d;
  logic [DATA_WIDTH-1:0]   merge_d;
  logic [7:0]              byte_lane;
  logic [15:0]             half_lane;

  assign req_ready  = (state_q == IDLE) & ~rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q[ADDR_WIDTH-1:2];
  assign mem_wdata  = merge_q;

  assign req_word_d = (req_ctrl[1:0] == 2'b10);

  // Illegal encodings first, then alignment of halfword and word accesses.
  always_comb begin
    req_err_d = 1'b0;
    if (req_write) begin
      req_err_d = !(req_ctrl inside {3'b000, 3'b001, 3'b010});
    end else begin
      req_err_d = !(req_ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    if ((req_ctrl[1:0] == 2'b01) && req_addr[0]) begin
      req_err_d = 1'b1;
    end
    if (req_word_d && (req_addr[1:0] != 2'b00)) begin
      req_err_d = 1'b1;
    end
  end

  assign byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_d = mem_rdata;
    case (ctrl_q)
      3'b000:  load_d = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      3'b001:  load_d = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      3'b100:  load_d = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      3'b101:  load_d = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: load_d = mem_rdata;
    endcase
  end

  always_comb begin
    merge_d = mem_rdata;
    if (ctrl_q[1:0] == 2'b00) begin
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ctrl_q       <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_rdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ctrl_q  <= req_ctrl;
            addr_q  <= req_addr;
            wdata_q <= req_wdata[15:0];
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_write && req_word_d) begin
              state_q  <= WRITE;
              merge_q  <= req_wdata;
              mem_en_q <= 1'b1;
              mem_we_q <= 1'b1;
            end else begin
              state_q  <= READ;
              mem_en_q <= 1'b1;
              mem_we_q <= 1'b0;
            end
          end
        end
        READ: begin
          mem_en_q <= 1'b0;
          state_q  <= DATA;
        end
        DATA: begin
          // A load stored ctrl with bit 2 or a non-store path ends here; stores go on to write.
          if (ctrl_q[2] || !(ctrl_q == 3'b000 || ctrl_q == 3'b001) || !write_path(state_q)) begin
            resp_rdata_q <= load_d;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            state_q      <= RESP;
          end else begin
            merge_q  <= merge_d;
            mem_en_q <= 1'b1;
            mem_we_q <= 1'b1;
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          mem_en_q     <= 1'b0;
          mem_we_q     <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Direction of the access in flight; held so DATA knows whether to respond or write back.
  logic write_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      write_q <= req_write;
    end
  end

  function automatic logic write_path(input state_t st);
    return (st == DATA) && write_q;
  endfunction

endmodule

// File: doc/data_mem_seq.md
# data_mem_seq

Sequencer between the load/store stage and a single-ported, word-wide synchronous data memory with one-cycle read latency. It accepts one access at a time using the `DATAMEMControl` funct3 encoding. It performs:
- loads as read, then byte-lane select and extend;
- sub-word stores as read-modify-write;
- word stores as a single write.

Misaligned and illegal accesses are rejected with an error response and never touch memory.

## Interface
- `DATA_WIDTH`, 32, data word width (fixed 4 byte lanes)
- `ADDR_WIDTH`, 32, byte address width; memory is word-addressed with `ADDR_WIDTH-2` bits
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `req_valid` in 1: access request present
- `req_ready` out 1: block can accept; `req_ready = (state==IDLE) & ~rst`
- `req_write` in 1: 1 = store, 0 = load
- `req_ctrl` in 3: `000` b, `001` h, `010` w, `100` bu, `101` hu
- `req_addr` in ADDR_WIDTH: byte address
- `req_wdata` in DATA_WIDTH: store data; low byte/half used for b/h
- `resp_valid` out 1: response held until accepted
- `resp_ready` in 1: consumer accepts response
- `resp_rdata` out DATA_WIDTH: extended load data; 0 for stores and errors
- `resp_err` out 1: misaligned or illegal access
- `mem_en` out 1: memory access this cycle
- `mem_we` out 1: write enable (valid with `mem_en`)
- `mem_addr` out ADDR_WIDTH-2: word address = latched `addr[ADDR_WIDTH-1:2]`
- `mem_wdata` out DATA_WIDTH: full write word
- `mem_rdata` in DATA_WIDTH: read word, valid the cycle after a read `mem_en`

## Operation
- States: IDLE, READ, DATA, WRITE, RESP.
- Request handshake completes on `req_valid & req_ready` in IDLE. At handshake, latch write, ctrl, addr and wdata.
- Error check at handshake:
  - load ctrl not in {000, 001, 010, 100, 101} → error;
  - store ctrl not in {000, 001, 010} → error;
  - h/hu with `addr[0]=1` → error;
  - w with `addr[1:0]!=0` → error.
- Transitions out of IDLE:
  - error → RESP with `resp_err=1`, `resp_rdata=0`;
  - load or sb/sh → READ;
  - sw → WRITE with merge register = `req_wdata`.
- READ: `mem_en=1`, `mem_we=0`; → DATA.
- DATA, which samples `mem_rdata`. Byte lane k = bits `[8k+7:8k]`, with k = `addr[1:0]`; half lane uses `addr[1]`.
  - load: register the extended value into `resp_rdata`. lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through. → RESP.
  - sb: merge = `mem_rdata` with lane k replaced by `wdata[7:0]`; → WRITE.
  - sh: merge = `mem_rdata` with lanes `{addr[1],0}` and `{addr[1],1}` replaced by `wdata[15:0]`; → WRITE.
- WRITE: `mem_en=1`, `mem_we=1`, `mem_wdata` = merge register; → RESP.
- RESP: `resp_valid=1`. Outputs stay stable until `resp_ready`. On `resp_ready` → IDLE.
- `mem_en` is never asserted in IDLE or RESP, and never for an erroring access.
- Outside WRITE, `mem_we=0`; `mem_wdata` is don't-care when `mem_we=0`.

## Timing
- Reset values (immediate, async): state IDLE, `req_ready=0` while `rst`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- Cycle numbering: handshake edge = cycle 0.
  - load: READ cycle 1, DATA cycle 2, `resp_valid` from cycle 3;
  - sb/sh: READ 1, DATA 2, WRITE 3, `resp_valid` from 4;
  - sw: WRITE 1, `resp_valid` from 2;
  - error: `resp_valid` from 1.
- Back-to-back: with `resp_ready` held high, RESP lasts one cycle and the next request is accepted the following cycle (IDLE). There is no overlap of accesses.
- `req_*` inputs are ignored outside IDLE. Latched values cannot change mid-access.
- Reset mid-operation: access abandoned, no partial write completed after reset edge, no response issued. A reset during WRITE may or may not have committed that cycle's write.

## Test plan
- Reset, then lw at `0x10`; memory word 4 = `0x8081_8283`. → `mem_en` read at cycle 1 with `mem_addr=4`; `resp_valid` at cycle 3; `resp_rdata=0x8081_8283`, `resp_err=0`.
- Same word: lb `0x11` → `0xFFFF_FF82`; lbu `0x13` → `0x0000_0080`; lh `0x12` → `0xFFFF_8081`; lhu `0x10` → `0x0000_8283`.
- Word = `0x1122_3344`; sb `0x12` with wdata `0xAB`. → read cycle 1; write cycle 3 with `mem_wdata=0x11AB_3344`; response cycle 4 with `rdata=0`.
- sh `0x12` with wdata `0xBEEF` on word `0x1122_3344` → `mem_wdata=0xBEEF_3344`. sw `0x10` with `0xDEAD_BEEF` → write at cycle 1, response at cycle 2.
- Misaligned lw `0x12`, lh `0x11`, store ctrl `100`, load ctrl `011`. → each gives `resp_err=1` at cycle 1, `rdata=0`, and `mem_en` never asserted.
- Hold `resp_ready=0` for 5 cycles after a load. → `resp_valid`/`resp_rdata` stable and `req_ready=0` throughout. Separately, assert `rst` during DATA of an sb → `mem_en=0` immediately, no write, IDLE after release.
